// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit: op encodings, FSM states,
// the per-operation sign/kind context and the iteration counter sizing.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  // What the FIX state needs to know about the op that was issued
  typedef struct packed {
    logic is_div;
    logic neg_lo;   // negate product (mult) or quotient (div)
    logic neg_hi;   // negate remainder (div only)
  } op_ctx_t;

  localparam int MULDIV_WIDTH = 32;

  // Counter must hold 0..width-1 with headroom
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int CNT_W = cnt_width(MULDIV_WIDTH);

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative engine shared by multiply and divide. The 2*WIDTH
// accumulator is loaded by the control logic, then stepped once per cycle:
//   mult: acc = {partial, multiplier}, shift-add, right shift
//   div : acc = {remainder, dividend}, restoring subtract, left shift
// After WIDTH steps acc holds {hi, lo} of the product or {rem, quot}.
module muldiv_iter_core
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   load_acc,
  input  logic [WIDTH-1:0]     load_m,
  output logic [2*WIDTH-1:0]   acc,
  output logic                 last
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0]   m;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_ext;
  logic [WIDTH-1:0]   diff;
  logic [2*WIDTH-1:0] acc_mul;
  logic [2*WIDTH-1:0] acc_div;

  // One step of each algorithm; the remainder is widened by one bit because
  // 2*rem+1 can exceed WIDTH bits before the compare.
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    acc_mul = {sum, acc[WIDTH-1:1]};
    rem_ext = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = rem_ext[WIDTH-1:0] - m;
    if (rem_ext >= {1'b0, m})
      acc_div = {diff, acc[WIDTH-2:0], 1'b1};
    else
      acc_div = {rem_ext[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  assign last = (cnt == CW'(WIDTH - 1));

  // Accumulator, operand and step counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      m   <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= load_acc;
      m   <= load_m;
      cnt <= '0;
    end else if (step) begin
      acc <= is_div ? acc_div : acc_mul;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// Multiply/divide unit owning architectural HI/LO. Signed ops are run on
// magnitudes and sign-corrected in FIX. stall_o is a pure decode of the
// registered state, so the issuing instruction itself never stalls.
// Optional build macro: MULDIV_FAST_MUL_EN (single-cycle multiplier; MULT and
// MULTU go straight to FIX; division stays iterative).
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             done_o
);

  state_e             state, next_state;
  op_ctx_t            ctx, ctx_d;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               core_load, core_step, core_last;
  logic [2*WIDTH-1:0] load_acc, acc;
  logic [WIDTH-1:0]   load_m;

  logic               sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic               do_write, mt_hi, mt_lo;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;
  logic [WIDTH-1:0]   res_hi, res_lo;

  // Operand magnitudes; unsigned ops pass operands through untouched
  always_comb begin
    sgn   = (op_i == OP_MULT) || (op_i == OP_DIV);
    a_mag = (sgn && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag = (sgn && b_i[WIDTH-1]) ? -b_i : b_i;
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .step     (core_step),
    .is_div   (ctx.is_div),
    .load_acc (load_acc),
    .load_m   (load_m),
    .acc      (acc),
    .last     (core_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next state, issue decode and core control
  always_comb begin
    next_state = state;
    core_load  = 1'b0;
    core_step  = 1'b0;
    load_acc   = '0;
    load_m     = '0;
    ctx_d      = ctx;
    do_write   = 1'b0;
    mt_hi      = 1'b0;
    mt_lo      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          case (op_i)
            OP_MULT, OP_MULTU: begin
              core_load    = 1'b1;
              ctx_d.is_div = 1'b0;
              ctx_d.neg_lo = sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              ctx_d.neg_hi = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
              load_acc     = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
              next_state   = S_FIX;
`else
              load_acc     = {{WIDTH{1'b0}}, b_mag};
              load_m       = a_mag;
              next_state   = S_RUN;
`endif
            end
            OP_DIV, OP_DIVU: begin
              core_load    = 1'b1;
              ctx_d.is_div = 1'b1;
              ctx_d.neg_hi = sgn && a_i[WIDTH-1];
              if (b_i == '0) begin
                // rem = |a| re-signed to the dividend gives HI = a_i;
                // LO stays all ones, so no quotient negate
                load_acc     = {a_mag, {WIDTH{1'b1}}};
                ctx_d.neg_lo = 1'b0;
                next_state   = S_FIX;
              end else begin
                load_acc     = {{WIDTH{1'b0}}, a_mag};
                load_m       = b_mag;
                ctx_d.neg_lo = sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                next_state   = S_RUN;
              end
            end
            OP_MTHI: mt_hi = 1'b1;
            OP_MTLO: mt_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (flush_i) begin
          next_state = S_IDLE;
        end else begin
          core_step = 1'b1;
          if (core_last) next_state = S_FIX;
        end
      end
      S_FIX: begin
        next_state = S_IDLE;
        do_write   = !flush_i;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Sign correction of the unsigned core result
  always_comb begin
    prod   = ctx.neg_lo ? -acc : acc;
    quot   = ctx.neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = ctx.neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res_hi = ctx.is_div ? rem  : prod[2*WIDTH-1:WIDTH];
    res_lo = ctx.is_div ? quot : prod[WIDTH-1:0];
  end

  // HI/LO architectural registers, op context and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      ctx    <= '0;
    end else begin
      done_q <= do_write;
      if (core_load) ctx <= ctx_d;
      if (do_write) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else begin
        if (mt_hi) hi_q <= a_i;
        if (mt_lo) lo_q <= a_i;
      end
    end
  end

  assign stall_o = (state != S_IDLE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit (WIDTH=32). Inputs are driven and
// outputs sampled on the falling edge.
module tb_muldiv_hilo_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = 33;
`endif
  localparam int DIV_STALL = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        stall;
  logic [31:0] hi, lo;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  logic iss_stall;
  int   cyc;
  logic dn;
  int   dcnt;

  always #5 clk = ~clk;

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .op_i    (op),
    .a_i     (a),
    .b_i     (b),
    .flush_i (flush),
    .stall_o (stall),
    .hi_o    (hi),
    .lo_o    (lo),
    .done_o  (done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one op for a single cycle; returns after the issuing edge
  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; op = o; a = av; b = bv;
    #1 iss_stall = stall;
    @(negedge clk);
    start = 1'b0; op = OP_NOP;
  endtask

  // Count stalled cycles (bounded) and report done at the release cycle
  task automatic wait_idle(output int c, output logic d);
    c = 0;
    while (stall && c < 200) begin
      c++;
      @(negedge clk);
    end
    d = done;
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_stall,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(o, av, bv);
    check({tag, "_issue_stall"}, 64'(iss_stall), 64'(0));
    wait_idle(cyc, dn);
    check({tag, "_stall_cycles"}, 64'(cyc), 64'(exp_stall));
    check({tag, "_done"}, 64'(dn), 64'(1));
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'(0));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = OP_NOP; a = '0; b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    rst = 1'b0;

    // MTLO: write at the issue edge, no stall, no done
    issue(OP_MTLO, 32'hDEADBEEF, 32'h0);
    check("mtlo_lo", 64'(lo), 64'hDEADBEEF);
    check("mtlo_stall", 64'(stall), 64'(0));
    check("mtlo_done", 64'(done), 64'(0));

    run_op("mult",  OP_MULT,  32'hFFFFFFFE, 32'd3, MUL_STALL, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", OP_MULTU, 32'hFFFFFFFE, 32'd3, MUL_STALL, 32'h00000002, 32'hFFFFFFFA);
    run_op("div",   OP_DIV,   32'hFFFFFFF9, 32'd2, DIV_STALL, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",  OP_DIVU,  32'd7,        32'd2, DIV_STALL, 32'h00000001, 32'h00000003);
    run_op("div0",  OP_DIV,   32'h00001234, 32'd0, 1,         32'h00001234, 32'hFFFFFFFF);
    run_op("div0n", OP_DIV,   32'hFFFFFFF9, 32'd0, 1,         32'hFFFFFFF9, 32'hFFFFFFFF);
    run_op("divmin", OP_DIV,  32'h80000000, 32'hFFFFFFFF, DIV_STALL, 32'h0, 32'h80000000);

    // Flush in cycle 10 of a DIV: back to IDLE, HI/LO untouched, no done
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    check("fl_busy", 64'(stall), 64'(1));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_stall", 64'(stall), 64'(0));
    check("fl_hi", 64'(hi), 64'(0));
    check("fl_lo", 64'(lo), 64'h80000000);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dcnt++;
      @(negedge clk);
    end
    check("fl_no_done", 64'(dcnt), 64'(0));
    check("fl_lo_after", 64'(lo), 64'h80000000);

    issue(OP_MTHI, 32'hA5A5A5A5, 32'h0);
    check("mthi_issue_stall", 64'(iss_stall), 64'(0));
    check("mthi_hi", 64'(hi), 64'hA5A5A5A5);
    check("mthi_stall", 64'(stall), 64'(0));

    // Flush alongside an MTLO issue suppresses the write
    flush = 1'b1;
    issue(OP_MTLO, 32'h00000055, 32'h0);
    flush = 1'b0;
    check("flmt_lo", 64'(lo), 64'h80000000);
    check("flmt_hi", 64'(hi), 64'hA5A5A5A5);

    // Asynchronous reset mid-RUN
    issue(OP_DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    check("ar_busy", 64'(stall), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("ar_hi", 64'(hi), 64'(0));
    check("ar_lo", 64'(lo), 64'(0));
    check("ar_stall", 64'(stall), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    issue(OP_MTLO, 32'h00000001, 32'h0);
    check("ar_mtlo", 64'(lo), 64'h1);
    check("ar_mtlo_stall", 64'(stall), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
